// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: one outstanding memory transaction shared by instruction refill (I) and data (D) requesters.
// Define ARB_STATS_EN to add saturating grant/conflict/busy counters.
module imem_dmem_arbiter #(
  parameter int FIXED_PRIO = 0
`ifdef ARB_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  grant
`ifdef ARB_STATS_EN
  , output logic [CNT_W-1:0] stat_i_grants,
  output logic [CNT_W-1:0] stat_d_grants,
  output logic [CNT_W-1:0] stat_conflicts,
  output logic [CNT_W-1:0] stat_busy_cycles
`endif
);
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
  state_t      state_q;
  logic        last_d_q, mem_valid_q, mem_instr_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_wstrb_q;
  logic [1:0]  grant_q;
  logic        idle, pick_i, pick_d, done;
  assign idle   = state_q == IDLE;
  // I wins alone, or on a round-robin tie when D owned the port last
  assign pick_i = i_valid && (!d_valid || (FIXED_PRIO == 0 && last_d_q));
  assign pick_d = d_valid && !pick_i;
  assign done   = mem_valid_q && mem_ready;
  // a requester that withdrew before completion gets no response
  assign i_ready = done && state_q == GNT_I && i_valid;
  assign d_ready = done && state_q == GNT_D && d_valid;
  assign i_rdata = i_ready ? mem_rdata : '0;
  assign d_rdata = d_ready ? mem_rdata : '0;
  assign mem_valid = mem_valid_q;
  assign mem_instr = mem_instr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign grant     = grant_q;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_instr_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      grant_q     <= '0;
    end else if (idle) begin
      if (pick_i || pick_d) begin
        state_q     <= pick_i ? GNT_I : GNT_D;
        last_d_q    <= pick_d;
        mem_valid_q <= 1'b1;
        mem_instr_q <= pick_i;
        mem_addr_q  <= pick_i ? i_addr : d_addr;
        mem_wdata_q <= pick_i ? '0 : d_wdata;
        mem_wstrb_q <= pick_i ? '0 : d_wstrb;
        grant_q     <= {pick_d, pick_i};
      end
    end else if (done) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_instr_q <= 1'b0;
      grant_q     <= '0;
    end
  end
`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] stat_i_q, stat_d_q, stat_c_q, stat_b_q;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + CNT_W'(1) : v;
  endfunction
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stat_i_q <= '0;
      stat_d_q <= '0;
      stat_c_q <= '0;
      stat_b_q <= '0;
    end else begin
      stat_i_q <= sat_inc(stat_i_q, idle && pick_i);
      stat_d_q <= sat_inc(stat_d_q, idle && pick_d);
      stat_c_q <= sat_inc(stat_c_q, idle && i_valid && d_valid);
      stat_b_q <= sat_inc(stat_b_q, mem_valid_q);
    end
  end
  assign stat_i_grants    = stat_i_q;
  assign stat_d_grants    = stat_d_q;
  assign stat_conflicts   = stat_c_q;
  assign stat_busy_cycles = stat_b_q;
`endif
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter: instance 0 is round-robin, instance 1 fixed-priority; both share requester inputs
// and each has its own latency-programmable memory responder.
module tb_imem_dmem_arbiter;
  logic clk = 0, resetn = 0;
  logic i_valid = 0, d_valid = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic [3:0] d_wstrb = 0;
  logic i_ready [2], d_ready [2], mem_valid [2], mem_instr [2], mem_ready [2];
  logic [31:0] i_rdata [2], d_rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];
  logic [3:0] mem_wstrb [2];
  logic [1:0] grant [2];
`ifdef ARB_STATS_EN
  logic [31:0] st_i [2], st_d [2], st_c [2], st_b [2];
`endif
  int n_cmp = 0, n_bad = 0, lat = 1;
  int cnt [2];
  bit hold = 0, fix = 0;
  logic [31:0] rfix = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    imem_dmem_arbiter #(.FIXED_PRIO(g)) u_dut (
      .clk(clk), .resetn(resetn),
      .i_valid(i_valid), .i_ready(i_ready[g]), .i_addr(i_addr), .i_rdata(i_rdata[g]),
      .d_valid(d_valid), .d_ready(d_ready[g]), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_rdata(d_rdata[g]),
      .mem_valid(mem_valid[g]), .mem_instr(mem_instr[g]), .mem_ready(mem_ready[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_wstrb(mem_wstrb[g]),
      .mem_rdata(mem_rdata[g]), .grant(grant[g])
`ifdef ARB_STATS_EN
      , .stat_i_grants(st_i[g]), .stat_d_grants(st_d[g]),
      .stat_conflicts(st_c[g]), .stat_busy_cycles(st_b[g])
`endif
    );
  end
  // memory responder: mem_valid stays high for exactly lat cycles unless hold is set
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (mem_valid[k] && !hold && cnt[k] >= lat - 1) begin
        mem_ready[k] = 1;
        mem_rdata[k] = fix ? rfix : $urandom;
        cnt[k] = 0;
      end else begin
        mem_ready[k] = 0;
        cnt[k] = (mem_valid[k] && !hold) ? cnt[k] + 1 : 0;
      end
    end
    #1;
  endtask
  task automatic do_reset();
    resetn = 0; i_valid = 0; d_valid = 0; hold = 0; fix = 0; lat = 1;
    step();
    step();
    resetn = 1;
  endtask
  task automatic wait_ready(input int k, output int c);
    c = 0;
    while (!(i_ready[k] || d_ready[k]) && c < 50) begin
      step();
      c++;
    end
  endtask
  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({mem_valid[k], mem_instr[k], grant[k], mem_wstrb[k]} !== 8'h0) begin
        n_bad++; $display("FAIL reset_ctl k=%0d: got %b want 0", k, {mem_valid[k], mem_instr[k], grant[k], mem_wstrb[k]});
      end
      n_cmp++;
      if ({mem_addr[k], mem_wdata[k], i_ready[k], d_ready[k]} !== 66'h0) begin
        n_bad++; $display("FAIL reset_data k=%0d: got %h/%h want 0", k, mem_addr[k], mem_wdata[k]);
      end
    end
  endtask
  task automatic test_i_read();
    int c;
    do_reset();
    lat = 4; fix = 1; rfix = 32'h13; i_addr = 32'h100; i_valid = 1;
    step();
    n_cmp++;
    if ({mem_valid[0], mem_instr[0], mem_wstrb[0], grant[0], mem_addr[0]} !== {1'b1, 1'b1, 4'h0, 2'b01, 32'h100}) begin
      n_bad++; $display("FAIL i_read_issue: got v=%b i=%b s=%h g=%b a=%h want 1 1 0 01 100", mem_valid[0], mem_instr[0], mem_wstrb[0], grant[0], mem_addr[0]);
    end
    wait_ready(0, c);
    n_cmp++;
    if (c !== 3) begin n_bad++; $display("FAIL i_read_latency: got %0d want 3", c); end
    n_cmp++;
    if ({i_ready[0], d_ready[0], i_rdata[0]} !== {2'b10, 32'h13}) begin
      n_bad++; $display("FAIL i_read_resp: got %b%b %h want 10 00000013", i_ready[0], d_ready[0], i_rdata[0]);
    end
    step();
    i_valid = 0;
    #1;
    n_cmp++;
    if ({i_ready[0], mem_valid[0]} !== 2'b00) begin n_bad++; $display("FAIL i_read_after: got %b%b want 00", i_ready[0], mem_valid[0]); end
  endtask
  task automatic test_d_write();
    int c;
    do_reset();
    lat = 2; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011; d_valid = 1;
    step();
    n_cmp++;
    if ({mem_instr[0], grant[0], mem_addr[0], mem_wdata[0], mem_wstrb[0]} !== {1'b0, 2'b10, 32'h2000, 32'hDEADBEEF, 4'b0011}) begin
      n_bad++; $display("FAIL d_write_issue: got i=%b g=%b a=%h w=%h s=%b", mem_instr[0], grant[0], mem_addr[0], mem_wdata[0], mem_wstrb[0]);
    end
    wait_ready(0, c);
    n_cmp++;
    if ({c == 1, i_ready[0], d_ready[0], d_rdata[0]} !== {3'b101, mem_rdata[0]}) begin
      n_bad++; $display("FAIL d_write_resp: got c=%0d %b%b %h want c=1 01 %h", c, i_ready[0], d_ready[0], d_rdata[0], mem_rdata[0]);
    end
    step();
    d_valid = 0;
  endtask
  // both requesters saturate a zero-latency memory: one grant per 2 cycles, I and D alternating
  task automatic test_back_to_back();
    bit pri = 0, prd = 0;
    do_reset();
    i_valid = 1; d_valid = 1;
    for (int c = 0; c < 16; c++) begin
      step();
      n_cmp++;
      if ({mem_valid[0], i_ready[0], d_ready[0]} !== {c % 2 == 0, c % 4 == 0, c % 4 == 2}) begin
        n_bad++; $display("FAIL b2b c=%0d: got v=%b ir=%b dr=%b", c, mem_valid[0], i_ready[0], d_ready[0]);
      end
      i_valid = !pri; d_valid = !prd;
      pri = i_ready[0]; prd = d_ready[0];
    end
    i_valid = 0; d_valid = 0;
  endtask
  task automatic test_fixed_prio();
    do_reset();
    i_valid = 1; d_valid = 1;
    step();
    n_cmp++;
    if ({mem_instr[1], grant[1]} !== 3'b010) begin n_bad++; $display("FAIL fp_tie: got %b want 010", {mem_instr[1], grant[1]}); end
    n_cmp++;
    if ({mem_instr[0], grant[0]} !== 3'b101) begin n_bad++; $display("FAIL rr_tie: got %b want 101", {mem_instr[0], grant[0]}); end
    i_valid = 0; d_valid = 0;
  endtask
  task automatic test_reset_mid();
    do_reset();
    hold = 1; d_addr = 32'h44; d_valid = 1;
    for (int c = 0; c < 7; c++) step();
    n_cmp++;
    if ({mem_valid[0], grant[0], d_ready[0]} !== 4'b1100) begin
      n_bad++; $display("FAIL unbounded_wait: got %b want 1100", {mem_valid[0], grant[0], d_ready[0]});
    end
    resetn = 0;
    step();
    n_cmp++;
    if ({mem_valid[0], grant[0], d_ready[0]} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_mid: got %b want 0000", {mem_valid[0], grant[0], d_ready[0]});
    end
    resetn = 1; hold = 0; i_valid = 1;
    step();
    n_cmp++;
    if ({mem_instr[0], grant[0]} !== 3'b101) begin n_bad++; $display("FAIL post_reset_tie: got %b want 101", {mem_instr[0], grant[0]}); end
    i_valid = 0; d_valid = 0;
  endtask
  task automatic test_idle_ready();
    do_reset();
    step();
    mem_ready[0] = 1;
    #1;
    n_cmp++;
    if ({i_ready[0], d_ready[0]} !== 2'b00) begin n_bad++; $display("FAIL idle_ready: got %b want 00", {i_ready[0], d_ready[0]}); end
    step();
    n_cmp++;
    if (mem_valid[0] !== 1'b0) begin n_bad++; $display("FAIL idle_ready_state: got %b want 0", mem_valid[0]); end
  endtask
  task automatic test_withdraw();
    int c = 0;
    do_reset();
    lat = 3; i_valid = 1;
    step();
    i_valid = 0;
    while (mem_valid[0] && c < 20) begin
      step();
      c++;
      n_cmp++;
      if (i_ready[0] !== 1'b0) begin n_bad++; $display("FAIL withdraw_ready: got %b want 0", i_ready[0]); end
    end
    n_cmp++;
    if (mem_valid[0] !== 1'b0) begin n_bad++; $display("FAIL withdraw_complete: got %b want 0", mem_valid[0]); end
  endtask
  // reference model: arbitration decided from the pending requests of the previous cycle
  task automatic test_random(input int k, input int n);
    bit p_i = 0, p_d = 0, pv = 0, pr = 0, ri = 0, rd = 0, ei = 0, r = 0, last_d = 1;
    logic [31:0] ea = 0, ew = 0;
    logic [3:0] es = 0;
    do_reset();
    for (int t = 0; t < n; t++) begin
      lat = $urandom_range(1, 4);
      step();
      if (!pr && !pv && (p_i || p_d)) begin
        ei = p_i && (!p_d || (k == 0 && last_d));
        last_d = !ei;
        ea = ei ? i_addr : d_addr; ew = ei ? 32'h0 : d_wdata; es = ei ? 4'h0 : d_wstrb;
        n_cmp++;
        if ({mem_valid[k], mem_instr[k], grant[k]} !== {1'b1, ei, !ei, ei}) begin
          n_bad++; $display("FAIL rnd_arb k=%0d t=%0d: got %b want %b", k, t, {mem_valid[k], mem_instr[k], grant[k]}, {1'b1, ei, !ei, ei});
        end
      end else begin
        n_cmp++;
        if (mem_valid[k] !== (pv && !pr)) begin
          n_bad++; $display("FAIL rnd_valid k=%0d t=%0d: got %b want %b", k, t, mem_valid[k], pv && !pr);
        end
      end
      if (mem_valid[k]) begin
        n_cmp++;
        if ({mem_addr[k], mem_wdata[k], mem_wstrb[k]} !== {ea, ew, es}) begin
          n_bad++; $display("FAIL rnd_payload k=%0d t=%0d: got %h %h %h want %h %h %h", k, t, mem_addr[k], mem_wdata[k], mem_wstrb[k], ea, ew, es);
        end
      end
      r = mem_valid[k] && mem_ready[k];
      n_cmp++;
      if ({i_ready[k], d_ready[k], i_rdata[k], d_rdata[k]} !== {r && ei, r && !ei, (r && ei) ? mem_rdata[k] : 32'h0, (r && !ei) ? mem_rdata[k] : 32'h0}) begin
        n_bad++; $display("FAIL rnd_resp k=%0d t=%0d: got %b%b %h %h", k, t, i_ready[k], d_ready[k], i_rdata[k], d_rdata[k]);
      end
      pr = r; pv = mem_valid[k];
      if (ri) i_valid = 0;
      else if (!i_valid && $urandom_range(0, 2) == 0) begin i_valid = 1; i_addr = $urandom; end
      if (rd) d_valid = 0;
      else if (!d_valid && $urandom_range(0, 2) == 0) begin
        d_valid = 1; d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom_range(0, 15));
      end
      ri = r && ei; rd = r && !ei;
      p_i = i_valid; p_d = d_valid;
    end
    i_valid = 0; d_valid = 0;
  endtask
`ifdef ARB_STATS_EN
  task automatic test_stats();
    int c;
    do_reset();
    lat = 2; i_valid = 1; d_valid = 1;
    wait_ready(0, c);
    step();
    i_valid = 0;
    wait_ready(0, c);
    step();
    d_valid = 0;
    for (int s = 0; s < 3; s++) begin
      if (s < 2) i_valid = 1; else d_valid = 1;
      step();
      wait_ready(0, c);
      step();
      i_valid = 0; d_valid = 0;
    end
    step();
    step();
    n_cmp++;
    if ({st_i[0], st_d[0], st_c[0], st_b[0]} !== {32'd3, 32'd2, 32'd1, 32'd10}) begin
      n_bad++; $display("FAIL stats: got i=%0d d=%0d c=%0d b=%0d want 3 2 1 10", st_i[0], st_d[0], st_c[0], st_b[0]);
    end
  endtask
`endif
  initial begin
    for (int k = 0; k < 2; k++) begin mem_ready[k] = 0; mem_rdata[k] = 0; cnt[k] = 0; end
    test_reset();
    test_i_read();
    test_d_write();
    test_back_to_back();
    test_fixed_prio();
    test_reset_mid();
    test_idle_ready();
    test_withdraw();
    test_random(0, 600);
    test_random(1, 600);
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
